// File: rtl/uart_reg_pkg.sv
// Shared constants and types for the UART register front end.
package uart_reg_pkg;

  // Register offsets
  localparam logic [2:0] AddrRbrThr = 3'd0;  // DLL when DLAB=1
  localparam logic [2:0] AddrIer    = 3'd1;  // DLM when DLAB=1
  localparam logic [2:0] AddrIir    = 3'd2;
  localparam logic [2:0] AddrLcr    = 3'd3;
  localparam logic [2:0] AddrLsr    = 3'd5;  // PSD when DLAB=1
  localparam logic [2:0] AddrScr    = 3'd7;

  // IIR codes, highest priority first
  localparam logic [7:0] IirRls  = 8'h06;
  localparam logic [7:0] IirRda  = 8'h04;
  localparam logic [7:0] IirThre = 8'h02;
  localparam logic [7:0] IirNone = 8'h01;

  // LCR bit positions
  localparam int unsigned LcrStop = 2;
  localparam int unsigned LcrPen  = 3;
  localparam int unsigned LcrEps  = 4;
  localparam int unsigned LcrDlab = 7;

  // LSR bit positions
  localparam int unsigned LsrDr   = 0;
  localparam int unsigned LsrOe   = 1;
  localparam int unsigned LsrPe   = 2;
  localparam int unsigned LsrFe   = 3;
  localparam int unsigned LsrThre = 5;
  localparam int unsigned LsrTemt = 6;

  // IER bit positions
  localparam int unsigned IerRda  = 0;
  localparam int unsigned IerThre = 1;
  localparam int unsigned IerRls  = 2;

  typedef enum logic {TxIdle, TxHold} tx_state_t;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt enable, THRE arming, IIR priority encoding and registered irq.
module uart_irq_ctrl
  import uart_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ier_wr,
  input  logic [7:0] wdata,
  input  logic       iir_rd,
  input  logic       thr_wr,
  input  logic       thre_arm,
  input  logic       dr,
  input  logic       rls,
  output logic [7:0] ier,
  output logic [7:0] iir,
  output logic       irq
);

  logic [2:0] ier_q, ier_d;
  logic       thre_pend_q, thre_pend_d;
  logic       irq_q, irq_d;

  assign ier = {5'b0, ier_q};
  assign irq = irq_q;

  // Priority encoder: line status > data ready > THR empty.
  always_comb begin
    iir = IirNone;
    if (ier_q[IerRls] && rls)              iir = IirRls;
    else if (ier_q[IerRda] && dr)          iir = IirRda;
    else if (ier_q[IerThre] && thre_pend_q) iir = IirThre;
  end

  // Next-state: IER, THRE pending (arming wins over clearing), irq level.
  always_comb begin
    ier_d       = ier_wr ? wdata[2:0] : ier_q;
    thre_pend_d = thre_pend_q;
    if ((iir_rd && iir == IirThre) || thr_wr) thre_pend_d = 1'b0;
    if (thre_arm || (ier_wr && wdata[IerThre] && !ier_q[IerThre])) thre_pend_d = 1'b1;
    irq_d = ~iir[0];
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_q       <= '0;
      thre_pend_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ier_q       <= ier_d;
      thre_pend_q <= thre_pend_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// 16550-style register front end for uart_top.
// Optional interrupt support is built when UART_IRQ_EN is defined; otherwise IER reads 0,
// IIR reads 0x01 and irq is tied low.
module uart_reg_ctrl
  import uart_reg_pkg::*;
#(
  parameter int unsigned DL_WIDTH        = 16,
  parameter int unsigned PSD_WIDTH       = 4,
  parameter int unsigned DEFAULT_DIVISOR = 651
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           bus_addr,
  input  logic                 bus_wr,
  input  logic                 bus_rd,
  input  logic [7:0]           bus_wdata,
  output logic [7:0]           bus_rdata,
  output logic                 bus_rvalid,
  output logic                 irq,
  output logic                 wr_en,
  output logic [7:0]           wr_data,
  input  logic                 tx_ready,
  output logic                 rd_en,
  input  logic [7:0]           rd_data,
  input  logic                 rx_ready,
  input  logic                 parity_err,
  input  logic                 framing_err,
  input  logic                 overrun_err,
  output logic [1:0]           stop_bits,
  output logic                 parity_en,
  output logic                 parity_even,
  output logic [3:0]           data_bits,
  output logic [DL_WIDTH-1:0]  divisor_latch,
  output logic [PSD_WIDTH-1:0] psd,
  output logic                 new_baud
);

  localparam logic [15:0] DefDiv = 16'(DEFAULT_DIVISOR);

  logic [7:0]           lcr_q, lcr_d, dll_q, dll_d, dlm_q, dlm_d, scr_q, scr_d;
  logic [PSD_WIDTH-1:0] psd_q, psd_d;
  logic                 boot_q, baud_dirty_q, baud_dirty_d, new_baud_q, new_baud_d;
  tx_state_t            tx_state_q, tx_state_d;
  logic [7:0]           tx_byte_q, tx_byte_d, wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
  logic [15:0]          dl_full;
  logic [7:0]           lsr, ier, iir, psd_rd, rd_mux;
  logic                 dlab, rd_acc, thr_wr, lcr_wr, lsr_rd, rbr_rd, tx_empty;

  // Access decode; a simultaneous write suppresses the read.
  assign dlab   = lcr_q[LcrDlab];
  assign rd_acc = bus_rd & ~bus_wr;
  assign thr_wr = bus_wr & (bus_addr == AddrRbrThr) & ~dlab;
  assign lcr_wr = bus_wr & (bus_addr == AddrLcr);
  assign rbr_rd = rd_acc & (bus_addr == AddrRbrThr) & ~dlab;
  assign lsr_rd = rd_acc & (bus_addr == AddrLsr) & ~dlab;

  // Outputs decoded from registers
  assign dl_full       = {dlm_q, dll_q};
  assign divisor_latch = dl_full[DL_WIDTH-1:0];
  assign psd           = psd_q;
  assign data_bits     = 4'd5 + {2'b00, lcr_q[1:0]};
  assign stop_bits     = lcr_q[LcrStop] ? 2'd2 : 2'd1;
  assign parity_en     = lcr_q[LcrPen];
  assign parity_even   = lcr_q[LcrEps];
  assign new_baud      = new_baud_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign rd_en         = rd_en_q;
  assign bus_rdata     = rdata_q;
  assign bus_rvalid    = rvalid_q;
  assign tx_empty      = tx_ready & (tx_state_q == TxIdle);

`ifdef UART_IRQ_EN
  logic ier_wr, iir_rd, thre_arm;
  assign ier_wr   = bus_wr & (bus_addr == AddrIer) & ~dlab;
  assign iir_rd   = rd_acc & (bus_addr == AddrIir);
  assign thre_arm = (tx_state_q == TxHold) & tx_ready;

  uart_irq_ctrl u_irq_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ier_wr   (ier_wr),
    .wdata    (bus_wdata),
    .iir_rd   (iir_rd),
    .thr_wr   (thr_wr),
    .thre_arm (thre_arm),
    .dr       (rx_ready),
    .rls      (oe_q | pe_q | fe_q),
    .ier      (ier),
    .iir      (iir),
    .irq      (irq)
  );
`else
  assign ier = 8'h00;
  assign iir = IirNone;
  assign irq = 1'b0;
`endif

  // Configuration registers and baud sequencing; boot_q forces the post-reset new_baud pulse.
  always_comb begin
    lcr_d        = lcr_wr ? bus_wdata : lcr_q;
    dll_d        = dll_q;
    dlm_d        = dlm_q;
    psd_d        = psd_q;
    scr_d        = (bus_wr && bus_addr == AddrScr) ? bus_wdata : scr_q;
    baud_dirty_d = baud_dirty_q;
    new_baud_d   = boot_q;
    if (bus_wr && dlab) begin
      unique case (bus_addr)
        AddrRbrThr: begin dll_d = bus_wdata; baud_dirty_d = 1'b1; end
        AddrIer:    begin dlm_d = bus_wdata; baud_dirty_d = 1'b1; end
        AddrLsr:    begin psd_d = bus_wdata[PSD_WIDTH-1:0]; baud_dirty_d = 1'b1; end
        default: ;
      endcase
    end
    if (lcr_wr && dlab && !bus_wdata[LcrDlab] && baud_dirty_q) begin
      new_baud_d   = 1'b1;
      baud_dirty_d = 1'b0;
    end
  end

  // TX path FSM: forward immediately when ready, otherwise hold one byte.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (thr_wr && tx_ready) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus_wdata;
        end else if (thr_wr) begin
          tx_byte_d  = bus_wdata;
          tx_state_d = TxHold;
        end
      end
      TxHold: begin
        if (tx_ready) begin
          wr_en_d    = 1'b1;
          wr_data_d  = tx_byte_q;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Status, sticky errors and registered read data.
  always_comb begin
    lsr = 8'h00;
    lsr[LsrDr]   = rx_ready;
    lsr[LsrOe]   = oe_q;
    lsr[LsrPe]   = pe_q;
    lsr[LsrFe]   = fe_q;
    lsr[LsrThre] = tx_empty;
    lsr[LsrTemt] = tx_empty;
    oe_d = (oe_q & ~lsr_rd) | overrun_err;
    pe_d = (pe_q & ~lsr_rd) | parity_err;
    fe_d = (fe_q & ~lsr_rd) | framing_err;
    psd_rd = 8'h00;
    psd_rd[PSD_WIDTH-1:0] = psd_q;
    unique case (bus_addr)
      AddrRbrThr: rd_mux = dlab ? dll_q : (rx_ready ? rd_data : 8'h00);
      AddrIer:    rd_mux = dlab ? dlm_q : ier;
      AddrIir:    rd_mux = iir;
      AddrLcr:    rd_mux = lcr_q;
      AddrLsr:    rd_mux = dlab ? psd_rd : lsr;
      AddrScr:    rd_mux = scr_q;
      default:    rd_mux = 8'h00;
    endcase
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? rd_mux : rdata_q;
    rd_en_d  = rbr_rd & rx_ready;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcr_q        <= 8'h03;
      dll_q        <= DefDiv[7:0];
      dlm_q        <= DefDiv[15:8];
      psd_q        <= '0;
      scr_q        <= 8'h00;
      boot_q       <= 1'b1;
      baud_dirty_q <= 1'b0;
      new_baud_q   <= 1'b0;
      tx_state_q   <= TxIdle;
      tx_byte_q    <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 8'h00;
      rd_en_q      <= 1'b0;
      rdata_q      <= 8'h00;
      rvalid_q     <= 1'b0;
      oe_q         <= 1'b0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
    end else begin
      lcr_q        <= lcr_d;
      dll_q        <= dll_d;
      dlm_q        <= dlm_d;
      psd_q        <= psd_d;
      scr_q        <= scr_d;
      boot_q       <= 1'b0;
      baud_dirty_q <= baud_dirty_d;
      new_baud_q   <= new_baud_d;
      tx_state_q   <= tx_state_d;
      tx_byte_q    <= tx_byte_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      oe_q         <= oe_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
    end
  end

endmodule
